btn_event_gen: RTL

BTN_EVENT_GEN -- requirements
Module: btn_event_gen

---
 rtl/btn_event_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/btn_event_gen.sv
// Purpose: per-channel button synchroniser + debouncer + edge/auto-repeat event strobe.
//          Optional auto-repeat FSM is compiled in with `define BTN_EVT_AUTOREPEAT_EN.
// Latency: raw change -> level after 2+DB_CYCLES edges, pulse one edge after level; no backpressure.
module btn_event_gen #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 20000,
  parameter int EDGE_MODE     = 0,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pulse
);

  localparam int            CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // Reject configurations that would silently misbehave.
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("btn_event_gen: EDGE_MODE must be 0, 1 or 2");
  end
  if (N_BTN < 1 || DB_CYCLES < 1 || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_event_gen: N_BTN, DB_CYCLES, HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end

`ifdef BTN_EVT_AUTOREPEAT_EN
  localparam int            HMAX      = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int            HW        = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_DELAY - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } ar_state_t;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          lvl;
    logic          lvl_d;
    logic          pls;
    logic [CW-1:0] cnt;
    logic          flip;
    logic          edge_evt;
    logic          rep_hit;

    // The level flips on this edge: DB_CYCLES-th consecutive disagreement.
    assign flip = (sync2 != lvl) && (cnt == DB_LAST);

    // Select which debounced transition produces an event strobe.
    always_comb begin
      edge_evt = 1'b0;
      case (EDGE_MODE)
        0:       edge_evt = lvl_d & ~lvl;
        1:       edge_evt = lvl & ~lvl_d;
        default: edge_evt = lvl ^ lvl_d;
      endcase
    end

`ifdef BTN_EVT_AUTOREPEAT_EN
    ar_state_t     state;
    logic [HW-1:0] hcnt;
    logic          rep_req;
    logic          rise_now;
    logic          fall_now;

    assign rise_now = flip & ~lvl;
    assign fall_now = flip & lvl;
    // A repeat request landing on the release edge is dropped.
    assign rep_hit  = rep_req & ~fall_now;

    // Auto-repeat FSM: hold timer, then periodic repeat requests while held.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        state   <= IDLE;
        hcnt    <= '0;
        rep_req <= 1'b0;
      end else begin
        rep_req <= 1'b0;
        if (fall_now) begin
          state <= IDLE;
          hcnt  <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise_now) begin
                state <= WAIT_HOLD;
                hcnt  <= '0;
              end
            end
            WAIT_HOLD: begin
              if (hcnt == HOLD_LAST) begin
                state   <= REPEAT;
                hcnt    <= '0;
                rep_req <= 1'b1;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
            REPEAT: begin
              if (hcnt == REP_LAST) begin
                hcnt    <= '0;
                rep_req <= 1'b1;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              hcnt  <= '0;
            end
          endcase
        end
      end
    end
`else
    assign rep_hit = 1'b0;
`endif

    // Synchronise, debounce and register the event strobe.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        cnt   <= '0;
        pls   <= 1'b0;
      end else begin
        sync1 <= btn[i];
        sync2 <= sync1;
        lvl_d <= lvl;
        pls   <= edge_evt | rep_hit;
        if (sync2 == lvl) begin
          cnt <= '0;
        end else if (flip) begin
          cnt <= '0;
          lvl <= ~lvl;
        end else if (cnt != DB_LAST) begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign level[i] = lvl;
    assign pulse[i] = pls;
  end

endmodule
